// File: rtl/inc_pulse_gen.sv
// Push-button conditioner: 2-flop synchronisers, press/release debounce, one inc_out pulse per press.
// Define INC_PULSE_GEN_AUTOREPEAT_EN to add hold-to-repeat pulses while the button stays held.
module inc_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic dir_in,
  output logic inc_out,
  output logic up_down_sel_out,
  output logic pressed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("inc_pulse_gen: all timing parameters must be >= 1");
  end

  logic [1:0]    btn_sync;
  logic [1:0]    dir_sync;
  logic          btn_s;
  logic          dir_s;
  logic [1:0]    state;
  logic [DW-1:0] deb_cnt;

  assign btn_s = btn_sync[1];
  assign dir_s = dir_sync[1];

`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
  localparam int REP_MAX_P = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX_P + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_MAX_P);

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;  // 0: waiting out the initial delay, 1: periodic repeats
  logic [RW-1:0] rep_target;

  assign rep_target = rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync        <= 2'b00;
      dir_sync        <= 2'b00;
      state           <= IDLE;
      deb_cnt         <= '0;
      inc_out         <= 1'b0;
      up_down_sel_out <= 1'b0;
      pressed         <= 1'b0;
`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
      rep_cnt         <= '0;
      rep_phase       <= 1'b0;
`endif
    end else begin
      btn_sync <= {btn_sync[0], btn_in};
      dir_sync <= {dir_sync[0], dir_in};
      inc_out  <= 1'b0;

      case (state)
        IDLE: begin
          // Direction only tracks the switch while no press is in progress.
          up_down_sel_out <= dir_s;
          if (btn_s) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end

        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            inc_out <= 1'b1;
            pressed <= 1'b1;
`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
`endif
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        HELD: begin
          if (!btn_s) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end
`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
          else if (rep_cnt == rep_target) begin
            inc_out   <= 1'b1;
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
          end else if (rep_cnt != REP_MAX) begin
            rep_cnt <= rep_cnt + RW'(1);
          end
`endif
        end

        DEB_RELEASE: begin
          if (btn_s) begin
            // Release was a glitch; repeat timing restarts from the full delay.
            state <= HELD;
`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
`endif
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            pressed <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Scoreboard bench for inc_pulse_gen: expected pulse edges are queued at stimulus time and
// matched by a monitor whenever inc_out is seen high.
module tb_inc_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef INC_PULSE_GEN_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic dir_in;
  logic inc_out;
  logic up_down_sel_out;
  logic pressed;

  int edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  inc_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .dir_in(dir_in),
    .inc_out(inc_out),
    .up_down_sel_out(up_down_sel_out),
    .pressed(pressed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Monitor: every inc_out pulse must match the oldest expected edge.
  always @(negedge clk) begin
    if (inc_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_inc", edge_cnt, -1);
      end else begin
        check("inc_edge", edge_cnt, exp_q.pop_front());
      end
      $display("inc pulse after edge %0d", edge_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Repeat pulses following a HELD entry at edge start, for HELD edges up to last.
  function automatic void push_repeats(input int start, input int last);
    int x;
    if (REPEAT_ON) begin
      x = start + RD;
      while (x <= last) begin
        exp_q.push_back(x);
        x += RP;
      end
    end
  endfunction

  // Press for hold cycles of raw high, then release; checks pulse(s) and pressed timing.
  task automatic do_press(input string tag, input int hold);
    int e, p, r;
    btn_in = 1'b1;
    e = edge_cnt + 1;
    p = e + D + 2;
    r = e + hold;
    exp_q.push_back(p);
    push_repeats(p, r + 1);
    wait_edge(p - 1);
    check({tag, "_pressed_pre"}, pressed, 0);
    wait_edge(p);
    check({tag, "_pressed_rise"}, pressed, 1);
    wait_edge(r - 1);
    btn_in = 1'b0;
    wait_edge(r + D + 1);
    check({tag, "_pressed_hold"}, pressed, 1);
    wait_edge(r + D + 2);
    check({tag, "_pressed_fall"}, pressed, 0);
    tick(3);
    check({tag, "_queue"}, exp_q.size(), 0);
    $display("%s: press %0d cycles done", tag, hold);
  endtask

  initial begin
    int e, p, r, g, q, e2, p2, r2;
    reset  = 1'b1;
    btn_in = 1'b0;
    dir_in = 1'b0;
    tick(3);
    check("rst_inc", inc_out, 0);
    check("rst_pressed", pressed, 0);
    check("rst_dir", up_down_sel_out, 0);
    reset = 1'b0;
    tick(3);

    // Single press, 30 cycles held.
    do_press("t1", 30);

    // Bouncing input: 2 high / 2 low never passes debounce.
    for (int i = 0; i < 40; i++) begin
      btn_in = ((i % 4) < 2);
      tick(1);
      check("t2_pressed", pressed, 0);
    end
    btn_in = 1'b0;
    tick(8);
    check("t2_queue", exp_q.size(), 0);

    // Hold long enough for repeats when enabled (release at P+27).
    do_press("t3", D + 2 + 27);

    // Direction frozen during a press.
    dir_in = 1'b0;
    tick(4);
    check("t4_dir_idle", up_down_sel_out, 0);
    btn_in = 1'b1;
    e = edge_cnt + 1;
    p = e + D + 2;
    r = e + 20;
    exp_q.push_back(p);
    push_repeats(p, r + 1);
    wait_edge(p + 1);
    dir_in = 1'b1;
    tick(6);
    check("t4_dir_held", up_down_sel_out, 0);
    wait_edge(r - 1);
    btn_in = 1'b0;
    wait_edge(r + D + 2);
    check("t4_dir_release", up_down_sel_out, 0);
    check("t4_pressed", pressed, 0);
    wait_edge(r + D + 3);
    check("t4_dir_idle_new", up_down_sel_out, 1);
    tick(3);
    check("t4_queue", exp_q.size(), 0);

    // Reset while HELD just before a repeat; button stays held through reset.
    btn_in = 1'b1;
    e = edge_cnt + 1;
    p = e + D + 2;
    exp_q.push_back(p);
    push_repeats(p, p + 8);
    wait_edge(p + 8);
    reset = 1'b1;
    wait_edge(p + 9);
    reset = 1'b0;
    check("t5_rst_inc", inc_out, 0);
    check("t5_rst_pressed", pressed, 0);
    check("t5_rst_dir", up_down_sel_out, 0);
    e2 = p + 10;
    p2 = e2 + D + 2;
    r2 = p2 + 12;
    exp_q.push_back(p2);
    push_repeats(p2, r2 + 1);
    wait_edge(p + 10);
    check("t5_post_inc", inc_out, 0);
    wait_edge(p2 - 1);
    check("t5_pressed_pre", pressed, 0);
    wait_edge(p2);
    check("t5_pressed_rise", pressed, 1);
    wait_edge(r2 - 1);
    btn_in = 1'b0;
    wait_edge(r2 + D + 2);
    check("t5_pressed_fall", pressed, 0);
    tick(3);
    check("t5_queue", exp_q.size(), 0);

    // Long hold with a 2-cycle low glitch in the middle.
    btn_in = 1'b1;
    e = edge_cnt + 1;
    p = e + D + 2;
    g = e + 500;
    q = g + 4;
    r = e + 1000;
    exp_q.push_back(p);
    push_repeats(p, g + 1);
    push_repeats(q, r + 1);
    for (int ed = p; ed <= r + D + 1; ed++) begin
      wait_edge(ed);
      check("t6_pressed", pressed, 1);
      if (ed == g - 1) btn_in = 1'b0;
      if (ed == g + 1) btn_in = 1'b1;
      if (ed == r - 1) btn_in = 1'b0;
    end
    wait_edge(r + D + 2);
    check("t6_pressed_fall", pressed, 0);
    tick(5);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inc_pulse_gen.md
Name: inc_pulse_gen

Overview:
- Front-end conditioner that produces the count-trigger impulse consumed by the digit counter's `inc` input, plus a stable count-direction select for its `up_down_sel` input.
- Converts a raw asynchronous push-button and direction switch into clean signals: synchronised, debounced, one `inc_out` pulse per press.
- Optional hold-to-repeat.
- Sits between the board I/O pins and the counter chain; one instance per user button.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a level must hold to be accepted (≥1).
- REPEAT_DELAY, 500, cycles held after the first pulse before the first repeat pulse (≥1).
- REPEAT_PERIOD, 100, cycles between subsequent repeat pulses (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous push-button, high = pressed.
- dir_in  input  1  raw asynchronous direction switch, 1 = down, 0 = up.
- inc_out  output  1  single-cycle count-trigger pulse; drives counter `inc`.
- up_down_sel_out  output  1  registered direction; drives counter `up_down_sel`.
- pressed  output  1  high while the button is accepted as held.

Behaviour:
- One clock, `clk`; reset is synchronous and active-high on `reset`. Reset is sampled only on the rising edge of `clk`.
- Reset values: `inc_out`=0, `up_down_sel_out`=0, `pressed`=0. Reset also puts the FSM in IDLE, clears all timers and clears both synchronisers.
- Synchronisers: `btn_in` and `dir_in` each pass through a 2-flop synchroniser; only the synchronised values (`btn_s`, `dir_s`) are used internally.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- IDLE:
  - `up_down_sel_out` <= `dir_s` every cycle.
  - `btn_s`=1 -> DEB_PRESS, debounce counter cleared.
- DEB_PRESS:
  - `btn_s`=0 -> IDLE, no pulse.
  - Otherwise the counter increments.
  - On reaching DEBOUNCE_CYCLES consecutive highs -> HELD; `inc_out`=1 for exactly one cycle; repeat timer cleared.
- HELD:
  - `pressed`=1.
  - `btn_s`=0 -> DEB_RELEASE, debounce counter cleared.
  - Repeat timer behaviour: see Optional Feature.
- DEB_RELEASE:
  - `pressed` stays 1.
  - `btn_s`=1 -> HELD, repeat timer cleared, no pulse.
  - DEBOUNCE_CYCLES consecutive lows -> IDLE, `pressed`=0.
- Latency: if edge N is the first edge sampling `btn_in` high and the level stays high, `inc_out` is high in the cycle following edge N+DEBOUNCE_CYCLES+2. `pressed` rises in that same cycle.
- `inc_out` is never high for two consecutive cycles.
- Direction is frozen outside IDLE: `dir_in` changes during a press take effect only after return to IDLE, so direction never changes between pulses of one press.
- Timer widths are `$clog2(param+1)`. Counters saturate, never wrap.
- Reset mid-operation: takes priority over all transitions. No pulse is emitted in the reset cycle or the cycle after. A button held through reset is re-debounced after reset deasserts and yields a fresh pulse.
- Glitch shorter than DEBOUNCE_CYCLES in either debounce state: returns to the prior stable state; no pulse, no `pressed` change.

Optional Feature:
- Macro `INC_PULSE_GEN_AUTOREPEAT_EN`.
- Defined: in HELD the repeat timer counts each cycle.
  - It emits `inc_out` REPEAT_DELAY cycles after the initial pulse.
  - It then emits every REPEAT_PERIOD cycles while in HELD.
  - Entering DEB_RELEASE pauses it. Returning to HELD restarts the full REPEAT_DELAY.
- Undefined: the repeat timer and its logic are absent; exactly one `inc_out` pulse per accepted press, regardless of hold duration.

Test Plan:
1. DEBOUNCE_CYCLES=4, `btn_in` first sampled high at edge 10, held 30 cycles, macro undefined -> single `inc_out` pulse in the cycle after edge 16; `pressed` high from then until 4 cycles of synchronised low after release.
2. DEBOUNCE_CYCLES=4, `btn_in` toggling 2 high / 2 low for 40 cycles, then low -> `inc_out` never asserted; `pressed` stays 0.
3. Macro defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, initial pulse at cycle P, held until P+27 -> pulses at P, P+10, P+15, P+20, P+25 (5 total), none after release.
4. `dir_in`=0 at press, toggled to 1 while HELD -> `up_down_sel_out` stays 0 until the FSM returns to IDLE, then becomes 1 within 1 cycle.
5. `reset` asserted for 1 cycle while HELD with repeat imminent -> next cycle all outputs 0, no pulse. With `btn_in` still high, a new pulse appears DEBOUNCE_CYCLES+2 edges after the first post-reset edge that samples `btn_in` high.
6. Macro undefined, `btn_in` held 1000 cycles with a 2-cycle low glitch mid-hold (DEBOUNCE_CYCLES=4) -> exactly one `inc_out` pulse; `pressed` never drops.
